// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one combinational ALU between two requesters.
// A round-robin grant picks one request in IDLE and latches its operands.
// The ALU result is registered in EXEC. RESP holds it until the granted
// requester consumes it.
//
// Ports
//   clk, rst_n              clock, asynchronous active-low reset
//   req_valid/req_ready     per-requester request handshake (bit i = requester i)
//   req_a*/req_b*/req_op*   operands and ALUOp for requesters 0 and 1
//   alu_a/alu_b/alu_op      latched operands driven to the shared ALU
//   alu_res                 combinational ALU result
//   rsp_valid/rsp_ready     per-requester response handshake
//   rsp_data                registered result, shared by both requesters
//   done_cnt                completed-operation counter (wraps)
//
// state | meaning
// IDLE  | arbitrate; accept one request and latch its operands
// EXEC  | ALU evaluates latched operands; result captured at the edge
// RESP  | hold rsp_valid/rsp_data for the granted requester until consumed
module alu_arbiter (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [1:0]  req_valid,
  output logic [1:0]  req_ready,
  input  logic [31:0] req_a0,
  input  logic [31:0] req_b0,
  input  logic [31:0] req_a1,
  input  logic [31:0] req_b1,
  input  logic [3:0]  req_op0,
  input  logic [3:0]  req_op1,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  output logic [3:0]  alu_op,
  input  logic [31:0] alu_res,
  output logic [1:0]  rsp_valid,
  input  logic [1:0]  rsp_ready,
  output logic [31:0] rsp_data,
  output logic [15:0] done_cnt
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t      state_q, state_d;
  logic        gnt_q, gnt_d;
  logic        last_grant_q, last_grant_d;
  logic [31:0] a_q, a_d;
  logic [31:0] b_q, b_d;
  logic [3:0]  op_q, op_d;
  logic [31:0] rsp_data_q, rsp_data_d;
  logic [15:0] done_cnt_q, done_cnt_d;
  logic        pick;

  // A tie goes to the requester that was not served last; otherwise the
  // single active requester wins.
  assign pick = (req_valid == 2'b11) ? ~last_grant_q : req_valid[1];

  always_comb begin
    state_d      = state_q;
    gnt_d        = gnt_q;
    last_grant_d = last_grant_q;
    a_d          = a_q;
    b_d          = b_q;
    op_d         = op_q;
    rsp_data_d   = rsp_data_q;
    done_cnt_d   = done_cnt_q;
    req_ready    = 2'b00;
    rsp_valid    = 2'b00;
    case (state_q)
      IDLE: begin
        if (req_valid != 2'b00) begin
          // The state register is already IDLE during reset, so gate the
          // combinational accept strobe with rst_n to keep it low there.
          req_ready = rst_n ? (pick ? 2'b10 : 2'b01) : 2'b00;
          gnt_d     = pick;
          a_d       = pick ? req_a1  : req_a0;
          b_d       = pick ? req_b1  : req_b0;
          op_d      = pick ? req_op1 : req_op0;
          state_d   = EXEC;
        end
      end
      EXEC: begin
        rsp_data_d = alu_res;
        state_d    = RESP;
      end
      RESP: begin
        rsp_valid = gnt_q ? 2'b10 : 2'b01;
        if (rsp_ready[gnt_q]) begin
          last_grant_d = gnt_q;
          done_cnt_d   = done_cnt_q + 16'd1;
          state_d      = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      gnt_q        <= 1'b0;
      last_grant_q <= 1'b1;
      a_q          <= '0;
      b_q          <= '0;
      op_q         <= '0;
      rsp_data_q   <= '0;
      done_cnt_q   <= '0;
    end else begin
      state_q      <= state_d;
      gnt_q        <= gnt_d;
      last_grant_q <= last_grant_d;
      a_q          <= a_d;
      b_q          <= b_d;
      op_q         <= op_d;
      rsp_data_q   <= rsp_data_d;
      done_cnt_q   <= done_cnt_d;
    end
  end

  assign alu_a    = a_q;
  assign alu_b    = b_q;
  assign alu_op   = op_q;
  assign rsp_data = rsp_data_q;
  assign done_cnt = done_cnt_q;

endmodule

// File: tb/tb_alu_arbiter.sv
module tb_alu_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  req_valid;
  logic [1:0]  req_ready;
  logic [31:0] req_a0, req_b0, req_a1, req_b1;
  logic [3:0]  req_op0, req_op1;
  logic [31:0] alu_a, alu_b;
  logic [3:0]  alu_op;
  logic [31:0] alu_res;
  logic [1:0]  rsp_valid;
  logic [1:0]  rsp_ready;
  logic [31:0] rsp_data;
  logic [15:0] done_cnt;

  int n_chk  = 0;
  int n_pass = 0;

  typedef struct {
    logic [1:0]  v;
    logic [31:0] a0, b0;
    logic [3:0]  op0;
    logic [31:0] a1, b1;
    logic [3:0]  op1;
    int          bp;
    logic [1:0]  junk;
    logic        g;
    logic [31:0] res;
    logic [15:0] cnt;
  } vec_t;

  typedef struct {
    logic        g;
    logic [31:0] res;
  } sb_t;

  vec_t vecs[10];
  sb_t  sb_q[$];

  alu_arbiter dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a0    (req_a0),
    .req_b0    (req_b0),
    .req_a1    (req_a1),
    .req_b1    (req_b1),
    .req_op0   (req_op0),
    .req_op1   (req_op1),
    .alu_a     (alu_a),
    .alu_b     (alu_b),
    .alu_op    (alu_op),
    .alu_res   (alu_res),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .done_cnt  (done_cnt)
  );

  always #5 clk = ~clk;

  // Shared ALU seen by the arbiter
  always_comb begin
    case (alu_op)
      4'b0000: alu_res = alu_a + alu_b;
      4'b1000: alu_res = alu_a - alu_b;
      4'b0001: alu_res = alu_a << alu_b[4:0];
      4'b0100: alu_res = alu_a ^ alu_b;
      4'b0101: alu_res = alu_a >> alu_b[4:0];
      4'b1101: alu_res = 32'($signed(alu_a) >>> alu_b[4:0]);
      4'b0110: alu_res = alu_a | alu_b;
      4'b0111: alu_res = alu_a & alu_b;
      default: alu_res = 32'h0;
    endcase
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  task automatic serve(input vec_t t);
    sb_t         e;
    int          n;
    logic [1:0]  oh;
    @(negedge clk);
    req_valid = t.v;
    req_a0 = t.a0; req_b0 = t.b0; req_op0 = t.op0;
    req_a1 = t.a1; req_b1 = t.b1; req_op1 = t.op1;
    rsp_ready = 2'b00;
    oh = t.g ? 2'b10 : 2'b01;
    #1;
    check("req_ready", 32'(req_ready), 32'(oh));
    sb_q.push_back('{t.g, t.res});
    @(negedge clk); #1;
    check("exec_req_ready", 32'(req_ready), 32'h0);
    check("exec_rsp_valid", 32'(rsp_valid), 32'h0);
    check("alu_op_latched", 32'(alu_op), 32'(t.g ? t.op1 : t.op0));
    n = 0;
    @(negedge clk); #1;
    while (rsp_valid == 2'b00 && n < 8) begin
      @(negedge clk); #1;
      n++;
    end
    e = sb_q.pop_front();
    check("rsp_latency", 32'(n), 32'h0);
    check("rsp_valid", 32'(rsp_valid), 32'(e.g ? 2'b10 : 2'b01));
    check("rsp_data", rsp_data, e.res);
    for (int i = 0; i < t.bp; i++) begin
      rsp_ready = t.junk & ~oh;
      @(negedge clk); #1;
      check("bp_rsp_valid", 32'(rsp_valid), 32'(oh));
      check("bp_rsp_data", rsp_data, e.res);
      check("bp_req_ready", 32'(req_ready), 32'h0);
    end
    rsp_ready = oh | (t.junk & ~oh);
    @(negedge clk);
    rsp_ready = 2'b00;
    req_valid = 2'b00;
    #1;
    check("done_cnt", 32'(done_cnt), 32'(t.cnt));
    check("post_rsp_valid", 32'(rsp_valid), 32'h0);
  endtask

  initial begin
    #400000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t w;
    //          v      a0            b0            op0      a1            b1           op1      bp junk   g     res            cnt
    vecs[0] = '{2'b11, 32'd10,       32'd4,        4'b1000, 32'hF0,       32'h0F,      4'b0100, 0, 2'b00, 1'b0, 32'd6,         16'd1};
    vecs[1] = '{2'b11, 32'd10,       32'd4,        4'b1000, 32'hF0,       32'h0F,      4'b0100, 0, 2'b00, 1'b1, 32'hFF,        16'd2};
    vecs[2] = '{2'b11, 32'd10,       32'd4,        4'b1000, 32'hF0,       32'h0F,      4'b0100, 0, 2'b00, 1'b0, 32'd6,         16'd3};
    vecs[3] = '{2'b11, 32'd10,       32'd4,        4'b1000, 32'hF0,       32'h0F,      4'b0100, 0, 2'b00, 1'b1, 32'hFF,        16'd4};
    vecs[4] = '{2'b01, 32'd5,        32'd3,        4'b0000, 32'h0,        32'h0,       4'b0000, 0, 2'b00, 1'b0, 32'd8,         16'd5};
    vecs[5] = '{2'b01, 32'd7,        32'd9,        4'b0000, 32'h0,        32'h0,       4'b0000, 0, 2'b00, 1'b0, 32'd16,        16'd6};
    vecs[6] = '{2'b11, 32'd5,        32'd3,        4'b0000, 32'hFFFFFFFF, 32'd1,       4'b0000, 5, 2'b01, 1'b1, 32'd0,         16'd7};
    vecs[7] = '{2'b11, 32'd3,        32'd5,        4'b1000, 32'd1,        32'd1,       4'b0000, 0, 2'b00, 1'b0, 32'hFFFFFFFE,  16'd8};
    vecs[8] = '{2'b10, 32'd0,        32'd0,        4'b0000, 32'h80000000, 32'd4,       4'b1101, 0, 2'b00, 1'b1, 32'hF8000000,  16'd9};
    vecs[9] = '{2'b01, 32'h0000F0F0, 32'h00000FF0, 4'b0111, 32'h0,        32'h0,       4'b0000, 2, 2'b10, 1'b0, 32'h000000F0,  16'd10};

    rst_n = 1'b0;
    req_valid = 2'b11;
    rsp_ready = 2'b00;
    req_a0 = '0; req_b0 = '0; req_a1 = '0; req_b1 = '0; req_op0 = '0; req_op1 = '0;
    repeat (2) @(negedge clk);
    #1;
    check("rst_req_ready", 32'(req_ready), 32'h0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'h0);
    check("rst_rsp_data", rsp_data, 32'h0);
    check("rst_alu_a", alu_a, 32'h0);
    check("rst_done_cnt", 32'(done_cnt), 32'h0);
    req_valid = 2'b00;
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 10; i++) serve(vecs[i]);

    // Counter wrap: preload the counter one short of overflow
    @(negedge clk);
    force dut.done_cnt_q = 16'hFFFF;
    #1;
    release dut.done_cnt_q;
    #1;
    check("wrap_preload", 32'(done_cnt), 32'h0000FFFF);
    w = '{2'b01, 32'd1, 32'd1, 4'b0001, 32'h0, 32'h0, 4'b0000, 0, 2'b00, 1'b0, 32'd2, 16'h0000};
    serve(w);

    // Reset while the op is in EXEC: everything drops, no response later
    @(negedge clk);
    req_valid = 2'b01; req_a0 = 32'd5; req_b0 = 32'd3; req_op0 = 4'b0000;
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("exec_rst_req_ready", 32'(req_ready), 32'h0);
    check("exec_rst_rsp_valid", 32'(rsp_valid), 32'h0);
    check("exec_rst_rsp_data", rsp_data, 32'h0);
    check("exec_rst_alu_a", alu_a, 32'h0);
    check("exec_rst_alu_b", alu_b, 32'h0);
    check("exec_rst_alu_op", 32'(alu_op), 32'h0);
    check("exec_rst_done_cnt", 32'(done_cnt), 32'h0);
    req_valid = 2'b00;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); #1;
      check("dropped_rsp_valid", 32'(rsp_valid), 32'h0);
    end

    // Tie right after reset goes to requester 0 again
    w = '{2'b11, 32'd10, 32'd4, 4'b1000, 32'hF0, 32'h0F, 4'b0100, 0, 2'b00, 1'b0, 32'd6, 16'd1};
    serve(w);
    check("sb_empty", 32'(sb_q.size()), 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
